// File: rtl/dcache_pkg.sv
// Shared types, default geometry and helpers for the set-associative data cache.
package dcache_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_WORDS  = 4;
  localparam int unsigned DEF_SETS   = 16;
  localparam int unsigned DEF_WAYS   = 2;

  localparam int unsigned OFF_W = $clog2(DEF_WORDS);
  localparam int unsigned IDX_W = $clog2(DEF_SETS);
  localparam int unsigned TAG_W = DEF_ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BLK_W = DEF_DATA_W * DEF_WORDS;

  // Widest word the merge helper handles; callers widen and truncate.
  localparam int unsigned MAX_DATA_W = 512;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWb,
    StRefillAr,
    StRefillR
  } state_e;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(input logic [MAX_DATA_W-1:0] word,
                                                       input logic [MAX_DATA_W-1:0] wdata,
                                                       input logic [MAX_STRB_W-1:0] wstrb);
    logic [MAX_DATA_W-1:0] res;
    res = word;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU victim selection and age update for the currently indexed set.
module dcache_lru #(
  parameter int unsigned WAYS = 2,
  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0][WayW-1:0] ages,
  input  logic [WAYS-1:0]           valids,
  input  logic [WayW-1:0]           hit_way,
  output logic [WayW-1:0]           victim,
  output logic [WAYS-1:0][WayW-1:0] ages_next
);

  if (WAYS == 1) begin : g_direct
    assign victim    = '0;
    assign ages_next = '0;
  end else begin : g_lru
    logic found;

    always_comb begin
      victim    = '0;
      found     = 1'b0;
      ages_next = ages;
      // Lowest-index invalid way wins; otherwise the oldest way.
      for (int w = 0; w < WAYS; w++) begin
        if (!valids[w] && !found) begin
          victim = WayW'(w);
          found  = 1'b1;
        end
      end
      if (!found) begin
        for (int w = 0; w < WAYS; w++) begin
          if (ages[w] == WayW'(WAYS - 1)) victim = WayW'(w);
        end
      end
      for (int w = 0; w < WAYS; w++) begin
        if (WayW'(w) == hit_way)           ages_next[w] = '0;
        else if (ages[w] < ages[hit_way])  ages_next[w] = ages[w] + 1'b1;
        else                               ages_next[w] = ages[w];
      end
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and independent AXI-style address/data handshakes to RAM.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic [ADDR_W-1:0]         cpu_req_addr,
  input  logic                      cpu_req_rw,
  input  logic [DATA_W/8-1:0]       cpu_req_wstrb,
  input  logic [DATA_W-1:0]         cpu_data_write,
  output logic                      cpu_resp_valid,
  output logic [DATA_W-1:0]         cpu_data_read,
  output logic                      dcache_hit,
  output logic [ADDR_W-1:0]         ram_axi_araddr,
  output logic                      ram_axi_arvalid,
  input  logic                      ram_axi_arready,
  input  logic [DATA_W*WORDS-1:0]   ram_axi_rdata,
  input  logic                      ram_axi_rvalid,
  output logic                      ram_axi_rready,
  output logic [ADDR_W-1:0]         ram_axi_awaddr,
  output logic                      ram_axi_awvalid,
  input  logic                      ram_axi_awready,
  output logic [DATA_W*WORDS-1:0]   ram_axi_wdata,
  output logic                      ram_axi_wvalid,
  input  logic                      ram_axi_wready
);

  localparam int unsigned OffW  = $clog2(WORDS);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = ADDR_W - IdxW - OffW;
  localparam int unsigned BlkW  = DATA_W * WORDS;
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] req_addr_q;
  logic              req_rw_q;
  logic [StrbW-1:0]  req_wstrb_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              first_q;
  logic [WayW-1:0]   victim_q;
  logic              resp_valid_q, hit_q;
  logic [DATA_W-1:0] rdata_q;
  logic              arvalid_q, awvalid_q, wvalid_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [BlkW-1:0]   wdata_q;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [TagW-1:0] tag_mem [WAYS][SETS];
  logic [BlkW-1:0] data_mem [WAYS][SETS];

  logic [OffW-1:0]  req_off;
  logic [IdxW-1:0]  req_idx;
  logic [TagW-1:0]  req_tag;
  logic             hit, accept, lookup_hit, refill_wr, victim_dirty;
  logic [WayW-1:0]  hit_way, lru_victim;
  logic [BlkW-1:0]  hit_blk;
  logic [DATA_W-1:0] hit_word, merged_word;
  logic [WAYS-1:0][WayW-1:0] set_ages, ages_next;

  assign req_off = req_addr_q[OffW-1:0];
  assign req_idx = req_addr_q[OffW +: IdxW];
  assign req_tag = req_addr_q[ADDR_W-1 -: TagW];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  assign hit_blk      = data_mem[hit_way][req_idx];
  assign hit_word     = hit_blk[req_off*DATA_W +: DATA_W];
  assign merged_word  = DATA_W'(byte_merge(MAX_DATA_W'(hit_word), MAX_DATA_W'(req_wdata_q),
                                           MAX_STRB_W'(req_wstrb_q)));
  assign lookup_hit   = (state_q == StLookup) && hit;
  assign refill_wr    = (state_q == StRefillR) && ram_axi_rvalid;
  assign victim_dirty = valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim];

  if (WAYS > 1) begin : g_age
    logic [WAYS-1:0][WayW-1:0] age_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WayW'(w);
        end
      end else if (lookup_hit) begin
        age_q[req_idx] <= ages_next;
      end
    end

    assign set_ages = age_q[req_idx];
  end else begin : g_no_age
    assign set_ages = '0;
  end

  dcache_lru #(
    .WAYS(WAYS)
  ) u_lru (
    .ages      (set_ages),
    .valids    (valid_q[req_idx]),
    .hit_way   (hit_way),
    .victim    (lru_victim),
    .ages_next (ages_next)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req_valid) begin
          accept  = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit)               state_d = StIdle;
        else if (victim_dirty) state_d = StWb;
        else                   state_d = StRefillAr;
      end
      StWb:       if (!awvalid_q && !wvalid_q) state_d = StRefillAr;
      StRefillAr: if (arvalid_q && ram_axi_arready) state_d = StRefillR;
      StRefillR:  if (ram_axi_rvalid) state_d = StLookup;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      req_rw_q     <= 1'b0;
      req_wstrb_q  <= '0;
      req_wdata_q  <= '0;
      first_q      <= 1'b0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      rdata_q      <= '0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      if (accept) begin
        req_addr_q  <= cpu_req_addr;
        req_rw_q    <= cpu_req_rw;
        req_wstrb_q <= cpu_req_wstrb;
        req_wdata_q <= cpu_data_write;
        first_q     <= 1'b1;
      end
      if (state_q == StLookup) begin
        if (hit) begin
          resp_valid_q <= 1'b1;
          hit_q        <= first_q;
          if (!req_rw_q) rdata_q <= hit_word;
        end else begin
          first_q  <= 1'b0;
          victim_q <= lru_victim;
          if (victim_dirty) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= {tag_mem[lru_victim][req_idx], req_idx, {OffW{1'b0}}};
            wdata_q   <= data_mem[lru_victim][req_idx];
          end else begin
            arvalid_q <= 1'b1;
            araddr_q  <= {req_tag, req_idx, {OffW{1'b0}}};
          end
        end
      end
      if (state_q == StWb) begin
        if (ram_axi_awready) awvalid_q <= 1'b0;
        if (ram_axi_wready)  wvalid_q  <= 1'b0;
        if (!awvalid_q && !wvalid_q) begin
          arvalid_q <= 1'b1;
          araddr_q  <= {req_tag, req_idx, {OffW{1'b0}}};
        end
      end
      if ((state_q == StRefillAr) && ram_axi_arready) arvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (lookup_hit && req_rw_q) begin
      dirty_q[req_idx][hit_way] <= 1'b1;
    end else if (refill_wr) begin
      valid_q[req_idx][victim_q] <= 1'b1;
      dirty_q[req_idx][victim_q] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (lookup_hit && req_rw_q) begin
      data_mem[hit_way][req_idx][req_off*DATA_W +: DATA_W] <= merged_word;
    end
    if (refill_wr) begin
      tag_mem[victim_q][req_idx]  <= req_tag;
      data_mem[victim_q][req_idx] <= ram_axi_rdata;
    end
  end

  assign cpu_req_ready   = (state_q == StIdle);
  assign cpu_resp_valid  = resp_valid_q;
  assign cpu_data_read   = rdata_q;
  assign dcache_hit      = hit_q;
  assign ram_axi_araddr  = araddr_q;
  assign ram_axi_arvalid = arvalid_q;
  assign ram_axi_rready  = (state_q == StRefillR);
  assign ram_axi_awaddr  = awaddr_q;
  assign ram_axi_awvalid = awvalid_q;
  assign ram_axi_wdata   = wdata_q;
  assign ram_axi_wvalid  = wvalid_q;

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the core's load/store unit and the block-wide RAM port. It generalises the two-way data cache with configurable ways, sets and block size, and adds:
- true-LRU replacement;
- byte-granular write strobes;
- a valid/ready request handshake;
- independent AXI-style address/data handshakes on the RAM side.

Hits complete in two cycles; misses stall the request until a dirty-victim writeback (if needed) and a refill have finished.

## Interface
- ADDR_W, 12, word address width; tag = ADDR_W - IDX_W - OFF_W.
- DATA_W, 64, CPU word width; multiple of 8.
- WORDS, 4, words per block; power of 2 and at least 2; OFF_W = log2(WORDS).
- SETS, 16, number of sets; power of 2; IDX_W = log2(SETS).
- WAYS, 2, associativity; must be 1, 2 or 4.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  cache can accept; high only in IDLE.
- cpu_req_addr  in  ADDR_W  word address.
- cpu_req_rw  in  1  0 = read, 1 = write.
- cpu_req_wstrb  in  DATA_W/8  byte enables for writes.
- cpu_data_write  in  DATA_W  write data.
- cpu_resp_valid  out  1  one-cycle pulse: request completed.
- cpu_data_read  out  DATA_W  read data; valid with cpu_resp_valid on reads.
- dcache_hit  out  1  one-cycle pulse on a first-lookup hit.
- ram_axi_araddr / arvalid / arready  out/out/in  ADDR_W/1/1  refill address, block-aligned.
- ram_axi_rdata / rvalid / rready  in/in/out  DATA_W*WORDS/1/1  refill data.
- ram_axi_awaddr / awvalid / awready  out/out/in  ADDR_W/1/1  writeback address, block-aligned.
- ram_axi_wdata / wvalid / wready  out/out/in  DATA_W*WORDS/1/1  writeback data.

## Operation
- Address fields: offset = [OFF_W-1:0], index = next IDX_W bits, tag = remaining MSBs.
- Per line: V, D, tag, block and an age field of log2(WAYS) bits (no age field when WAYS = 1).
- **IDLE:**
  - cpu_req_ready = 1.
  - On valid && ready, latch addr, rw, wstrb and wdata, then go to LOOKUP.
- **LOOKUP:** compare the tag against all ways of the set.
  - **Hit**, read: register the word and pulse cpu_resp_valid.
  - **Hit**, write: merge the bytes where the strobe bit is 1, set D, pulse cpu_resp_valid.
  - **Hit**, both cases: update LRU, return to IDLE.
  - **Miss:** choose the victim:
    - the lowest-index invalid way if one exists;
    - otherwise the way with age == WAYS-1.
  - Victim V&D = 1 → WB; otherwise → REFILL_AR.
- **WB:**
  - awvalid and wvalid rise on entry.
  - awaddr = {victim tag, index, 0}; wdata = victim block.
  - Each valid drops in the cycle after its own handshake; the two handshakes may complete in either order or together.
  - When both are done → REFILL_AR.
- **REFILL_AR:**
  - araddr = {req tag, index, 0}; hold arvalid until arready.
  - Then → REFILL_R.
- **REFILL_R:**
  - rready = 1.
  - On rvalid, write the victim line as V=1, D=0, new tag, rdata.
  - Then → LOOKUP, which now hits; a write miss completes there.
- **LRU update:** the accessed way's age becomes 0; every other way in the set whose age is below the accessed way's old age increments. A refill does not touch ages; the following LOOKUP hit updates them.
- dcache_hit pulses only when the first LOOKUP of a request hits, not on the post-refill lookup.

## Timing
- Reset values:
  - state = IDLE; all V, D = 0; ages = way index.
  - Every output = 0 except cpu_req_ready = 1.
  - The data and tag arrays are not reset.
- Hit latency: acceptance at edge 0, LOOKUP in cycle 1, cpu_resp_valid high in cycle 2, cpu_req_ready high again in cycle 2.
- Miss, clean victim, zero-wait RAM: resp in cycle 5.
- Miss, dirty victim, zero-wait RAM: add 2 cycles.
- All RAM valids are registered and stay stable until their handshake; addresses and data do not change while valid is high.
- Exactly one request is outstanding; cpu_req_* is ignored while not in IDLE.
- An rvalid or ready that arrives outside the matching state is ignored.
- Reset mid-operation: outputs drop immediately (asynchronous), the transaction is abandoned and all lines are invalidated. The RAM side must be reset alongside.
- WAYS = 1: no age storage and no LRU logic; the victim is always way 0.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, LOOKUP, WB, REFILL_AR, REFILL_R);
  - localparam derivations OFF_W, IDX_W, TAG_W, BLK_W;
  - a byte-merge function (block word, wdata, wstrb) → new word.
- Sub-module dcache_lru: combinational victim choice plus the next-age vector for one set (inputs: ages, valids, hit way). It is instantiated once, on the indexed set.

## Test plan
All scenarios use default parameters.
- **Cold read miss:** read 0x004 with RAM returning pattern P and arready/rvalid one cycle late.
  - Required: araddr 0x004, no aw.
  - resp = word 0 of P; dcache_hit stays 0.
  - Repeat read of 0x004: resp in 2 cycles, dcache_hit = 1.
- **Strobed write hit:** with 0x005 resident, write 0xFFFF_FFFF_FFFF_FFFF to 0x005 with wstrb = 0x0F.
  - Required: reading 0x005 returns the old upper 32 bits with the lower 32 bits all 1s.
- **LRU eviction:**
  - Fill 0x004 and 0x044, then read 0x004, then read 0x084.
  - Required: the line for 0x044 is evicted (a later read of 0x044 misses); 0x004 still hits.
- **Dirty writeback:**
  - Write 0x044, then cause two more misses in set 1 so that 0x044 becomes LRU.
  - Required: awaddr = 0x044, wdata carries the written word, followed by a refill.
- **Handshake skew:**
  - Apply wready 3 cycles before awready, then awready 3 cycles before wready.
  - Required: each valid drops independently and exactly one refill follows each time.
- **Reset mid-refill:**
  - Assert rst while in REFILL_R.
  - Required: rready and arvalid go to 0 asynchronously; after release, a read of the same address misses.
